// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM encoding and frame helper for the UART command decoder.
package uart_cmd_pkg;

    localparam int unsigned FRAME_W = 48;

    localparam logic [7:0] CMD_RUN      = 8'h52;
    localparam logic [7:0] CMD_STOP     = 8'h53;
    localparam logic [7:0] CMD_ADS_RREG = 8'h61;
    localparam logic [7:0] CMD_MPR_RREG = 8'h6D;

    localparam logic [7:0] HDR_ADS = 8'h41;
    localparam logic [7:0] HDR_MPR = 8'h4D;

    localparam logic [7:0] RREG_ERR_DATA = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_ADS_RREG = 3'd2,
        ST_MPR_RREG = 3'd3,
        ST_REPLY    = 3'd4
    } state_e;

    function automatic logic [FRAME_W-1:0] build_reply(input logic [7:0] hdr,
                                                       input logic [7:0] addr,
                                                       input logic [7:0] data);
        return {hdr, addr, data, 24'h000000};
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of all non-clock/reset signals of the UART command decoder.
// master = decoder side, slave = UART controller / sensor cores side.
interface uart_cmd_decoder_if;
    import uart_cmd_pkg::*;

    logic [15:0]        i_UART_DATA_RX;
    logic               i_UART_DATA_RX_VALID;
    logic               o_CORE_BUSY;
    logic               o_RUN;
    logic               o_ADS_RREG_REQ;
    logic               o_MPR_RREG_REQ;
    logic [7:0]         o_RREG_ADDR;
    logic               i_ADS_RREG_DONE;
    logic               i_MPR_RREG_DONE;
    logic [7:0]         i_ADS_RREG_DATA;
    logic [7:0]         i_MPR_RREG_DATA;
    logic [FRAME_W-1:0] i_SAMPLE_DATA;
    logic               i_SAMPLE_VALID;
    logic               o_SAMPLE_READY;
    logic [FRAME_W-1:0] o_UART_DATA_TX;
    logic               o_UART_DATA_TX_VALID;
    logic               i_UART_DATA_TX_READY;
    logic               o_CMD_ERR;

    modport master (
        input  i_UART_DATA_RX, i_UART_DATA_RX_VALID,
        input  i_ADS_RREG_DONE, i_MPR_RREG_DONE, i_ADS_RREG_DATA, i_MPR_RREG_DATA,
        input  i_SAMPLE_DATA, i_SAMPLE_VALID, i_UART_DATA_TX_READY,
        output o_CORE_BUSY, o_RUN, o_ADS_RREG_REQ, o_MPR_RREG_REQ, o_RREG_ADDR,
        output o_SAMPLE_READY, o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_CMD_ERR
    );

    modport slave (
        output i_UART_DATA_RX, i_UART_DATA_RX_VALID,
        output i_ADS_RREG_DONE, i_MPR_RREG_DONE, i_ADS_RREG_DATA, i_MPR_RREG_DATA,
        output i_SAMPLE_DATA, i_SAMPLE_VALID, i_UART_DATA_TX_READY,
        input  o_CORE_BUSY, o_RUN, o_ADS_RREG_REQ, o_MPR_RREG_REQ, o_RREG_ADDR,
        input  o_SAMPLE_READY, o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_CMD_ERR
    );

endinterface

// File: rtl/uart_tx_skid.sv
// One-entry sample buffer feeding the TX mux. Ready is registered (low out of
// reset), so a load and a drain never coincide.
module uart_tx_skid
    import uart_cmd_pkg::*;
(
    input  logic               i_CLK,
    input  logic               i_RSTN,
    input  logic [FRAME_W-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_drain,
    output logic               o_full,
    output logic [FRAME_W-1:0] o_data
);

    logic               full_q,  full_d;
    logic               ready_q, ready_d;
    logic [FRAME_W-1:0] data_q,  data_d;
    logic               load_s;

    assign load_s = i_valid && ready_q;

    // Buffer occupancy and payload next-state.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load_s) begin
            full_d = 1'b1;
            data_d = i_data;
        end else if (i_drain) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
        ready_d = !full_d;
    end

    // Buffer registers.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign o_ready = ready_q;
    assign o_full  = full_q;
    assign o_data  = data_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// PC command decoder: RUN/STOP streaming control, single-register reads, TX merge.
// Optional macro UART_CMD_TIMEOUT_EN enables the register-read timeout.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned P_RREG_TIMEOUT = 1_000_000
) (
    input  logic             i_CLK,
    input  logic             i_RSTN,
    uart_cmd_decoder_if.master bus
);

    state_e             state_q, state_d;
    logic [7:0]         addr_q, addr_d;
    logic [FRAME_W-1:0] reply_q, reply_d;
    logic               err_q, err_d;
    logic               reply_lock_q, reply_lock_d;

    logic [7:0]         cmd_s, rx_addr_s;
    logic               cmd_v_s;
    logic               done_s, timeout_s;
    logic [7:0]         rdata_s, hdr_s;
    logic               run_s, ads_req_s, mpr_req_s, busy_s;

    logic               skid_full_s, skid_drain_s, skid_ready_s;
    logic [FRAME_W-1:0] skid_data_s;
    logic               sel_sample_s, reply_offer_s, tx_valid_s, reply_xfer_s;
    logic [FRAME_W-1:0] tx_data_s;

    assign cmd_s     = bus.i_UART_DATA_RX[15:8];
    assign rx_addr_s = bus.i_UART_DATA_RX[7:0];
    assign cmd_v_s   = bus.i_UART_DATA_RX_VALID;

    // Completion/data of the core that owns the pending read; the other core is ignored.
    always_comb begin
        done_s  = 1'b0;
        rdata_s = 8'h00;
        hdr_s   = HDR_ADS;
        case (state_q)
            ST_ADS_RREG: begin
                done_s  = bus.i_ADS_RREG_DONE;
                rdata_s = bus.i_ADS_RREG_DATA;
                hdr_s   = HDR_ADS;
            end
            ST_MPR_RREG: begin
                done_s  = bus.i_MPR_RREG_DONE;
                rdata_s = bus.i_MPR_RREG_DATA;
                hdr_s   = HDR_MPR;
            end
            default: begin
                done_s  = 1'b0;
            end
        endcase
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(P_RREG_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             in_rreg_s;

    assign in_rreg_s = (state_q == ST_ADS_RREG) || (state_q == ST_MPR_RREG);

    // Cycles spent waiting on the current read; restarts on every new read.
    always_comb begin
        if (in_rreg_s) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // Timeout counter register.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_s = in_rreg_s && (tmo_cnt_q == TMO_W'(P_RREG_TIMEOUT - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // FSM state register plus the data registers it owns.
    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q      <= ST_IDLE;
            addr_q       <= 8'h00;
            reply_q      <= '0;
            err_q        <= 1'b0;
            reply_lock_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            reply_q      <= reply_d;
            err_q        <= err_d;
            reply_lock_q <= reply_lock_d;
        end
    end

    // FSM next-state logic; a command that cannot be honoured raises the error pulse.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        reply_d = reply_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_v_s) begin
                    case (cmd_s)
                        CMD_RUN:      state_d = ST_RUN;
                        CMD_STOP:     state_d = ST_IDLE;
                        CMD_ADS_RREG: begin
                            state_d = ST_ADS_RREG;
                            addr_d  = rx_addr_s;
                        end
                        CMD_MPR_RREG: begin
                            state_d = ST_MPR_RREG;
                            addr_d  = rx_addr_s;
                        end
                        default:      err_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cmd_v_s) begin
                    case (cmd_s)
                        CMD_STOP: state_d = ST_IDLE;
                        CMD_RUN:  state_d = ST_RUN;
                        default:  err_d = 1'b1;
                    endcase
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ADS_RREG, ST_MPR_RREG: begin
                if (done_s) begin
                    reply_d = build_reply(hdr_s, addr_q, rdata_s);
                    state_d = ST_REPLY;
                    err_d   = cmd_v_s;
                end else if (timeout_s) begin
                    reply_d = build_reply(hdr_s, addr_q, RREG_ERR_DATA);
                    state_d = ST_REPLY;
                    err_d   = 1'b1;
                end else begin
                    err_d   = cmd_v_s;
                end
            end
            ST_REPLY: begin
                err_d = cmd_v_s;
                if (reply_xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the registered state.
    always_comb begin
        run_s     = 1'b0;
        ads_req_s = 1'b0;
        mpr_req_s = 1'b0;
        case (state_q)
            ST_RUN:      run_s     = 1'b1;
            ST_ADS_RREG: ads_req_s = 1'b1;
            ST_MPR_RREG: mpr_req_s = 1'b1;
            default:     run_s     = 1'b0;
        endcase
        busy_s = (state_q != ST_IDLE);
    end

    uart_tx_skid u_skid (
        .i_CLK   (i_CLK),
        .i_RSTN  (i_RSTN),
        .i_data  (bus.i_SAMPLE_DATA),
        .i_valid (bus.i_SAMPLE_VALID),
        .o_ready (skid_ready_s),
        .i_drain (skid_drain_s),
        .o_full  (skid_full_s),
        .o_data  (skid_data_s)
    );

    // TX merge: the buffered sample wins, except that a reply already on offer
    // is held until it transfers so the frame never changes under VALID.
    always_comb begin
        sel_sample_s  = skid_full_s && !reply_lock_q;
        reply_offer_s = (state_q == ST_REPLY) && !sel_sample_s;
        tx_valid_s    = sel_sample_s || reply_offer_s;
        if (sel_sample_s) begin
            tx_data_s = skid_data_s;
        end else if (reply_offer_s) begin
            tx_data_s = reply_q;
        end else begin
            tx_data_s = '0;
        end
        skid_drain_s  = sel_sample_s && bus.i_UART_DATA_TX_READY;
        reply_xfer_s  = reply_offer_s && bus.i_UART_DATA_TX_READY;
        reply_lock_d  = reply_offer_s && !bus.i_UART_DATA_TX_READY;
    end

    assign bus.o_CORE_BUSY          = busy_s;
    assign bus.o_RUN                = run_s;
    assign bus.o_ADS_RREG_REQ       = ads_req_s;
    assign bus.o_MPR_RREG_REQ       = mpr_req_s;
    assign bus.o_RREG_ADDR          = addr_q;
    assign bus.o_SAMPLE_READY       = skid_ready_s;
    assign bus.o_UART_DATA_TX       = tx_data_s;
    assign bus.o_UART_DATA_TX_VALID = tx_valid_s;
    assign bus.o_CMD_ERR            = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed self-checking bench for uart_cmd_decoder (timeout case only with UART_CMD_TIMEOUT_EN).
module tb_uart_cmd_decoder;

    logic clk;
    logic rstn;
    int   vectors;
    int   miscompares;

    uart_cmd_decoder_if bus ();

`ifdef UART_CMD_TIMEOUT_EN
    uart_cmd_decoder #(.P_RREG_TIMEOUT(16)) dut (
        .i_CLK  (clk),
        .i_RSTN (rstn),
        .bus    (bus)
    );
`else
    uart_cmd_decoder dut (
        .i_CLK  (clk),
        .i_RSTN (rstn),
        .bus    (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [7:0] addr);
        bus.i_UART_DATA_RX       = {cmd, addr};
        bus.i_UART_DATA_RX_VALID = 1'b1;
        tick();
        bus.i_UART_DATA_RX_VALID = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn = 1'b0;
        bus.i_UART_DATA_RX       = 16'h0000;
        bus.i_UART_DATA_RX_VALID = 1'b0;
        bus.i_ADS_RREG_DONE      = 1'b0;
        bus.i_MPR_RREG_DONE      = 1'b0;
        bus.i_ADS_RREG_DATA      = 8'h00;
        bus.i_MPR_RREG_DATA      = 8'h00;
        bus.i_SAMPLE_DATA        = 48'h0;
        bus.i_SAMPLE_VALID       = 1'b0;
        bus.i_UART_DATA_TX_READY = 1'b0;
        #1;
        // reset state
        chk("rst_run",    64'(bus.o_RUN), 64'h0);
        chk("rst_busy",   64'(bus.o_CORE_BUSY), 64'h0);
        chk("rst_ready",  64'(bus.o_SAMPLE_READY), 64'h0);
        chk("rst_txv",    64'(bus.o_UART_DATA_TX_VALID), 64'h0);
        chk("rst_req",    64'({bus.o_ADS_RREG_REQ, bus.o_MPR_RREG_REQ, bus.o_CMD_ERR}), 64'h0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        chk("ready_after_rst", 64'(bus.o_SAMPLE_READY), 64'h1);

        // RUN / STOP
        send_cmd(8'h52, 8'h00);
        chk("run_on",  64'(bus.o_RUN), 64'h1);
        chk("run_busy", 64'(bus.o_CORE_BUSY), 64'h1);
        tick();
        chk("run_held", 64'(bus.o_RUN), 64'h1);
        send_cmd(8'h53, 8'h00);
        chk("run_off", 64'({bus.o_RUN, bus.o_CORE_BUSY}), 64'h0);

        // RREG while running, illegal code in idle
        send_cmd(8'h52, 8'h00);
        send_cmd(8'h6D, 8'h5D);
        chk("err_run_rreg", 64'({bus.o_CMD_ERR, bus.o_RUN, bus.o_MPR_RREG_REQ}), 64'b110);
        tick();
        chk("err_run_pulse", 64'(bus.o_CMD_ERR), 64'h0);
        send_cmd(8'h53, 8'h00);
        send_cmd(8'h7A, 8'h00);
        chk("err_idle_bad", 64'({bus.o_CMD_ERR, bus.o_CORE_BUSY}), 64'b10);
        tick();
        chk("err_idle_pulse", 64'(bus.o_CMD_ERR), 64'h0);

        // ADS register read
        send_cmd(8'h61, 8'h01);
        chk("ads_req", 64'({bus.o_ADS_RREG_REQ, bus.o_MPR_RREG_REQ, bus.o_CORE_BUSY}), 64'b101);
        chk("ads_addr", 64'(bus.o_RREG_ADDR), 64'h01);
        repeat (9) tick();
        bus.i_MPR_RREG_DONE = 1'b1;
        bus.i_MPR_RREG_DATA = 8'h55;
        tick();
        bus.i_MPR_RREG_DONE = 1'b0;
        chk("wrong_done", 64'({bus.o_ADS_RREG_REQ, bus.o_UART_DATA_TX_VALID}), 64'b10);
        bus.i_ADS_RREG_DONE = 1'b1;
        bus.i_ADS_RREG_DATA = 8'h73;
        tick();
        bus.i_ADS_RREG_DONE = 1'b0;
        chk("ads_txv",   64'(bus.o_UART_DATA_TX_VALID), 64'h1);
        chk("ads_frame", 64'(bus.o_UART_DATA_TX), 64'h4101_7300_0000);
        chk("ads_req_drop", 64'({bus.o_ADS_RREG_REQ, bus.o_CORE_BUSY}), 64'b01);
        repeat (2) tick();
        chk("ads_hold", 64'({bus.o_UART_DATA_TX_VALID, bus.o_UART_DATA_TX}), {16'h0, 1'b1, 48'h4101_7300_0000} & 64'h1_FFFF_FFFF_FFFF);
        bus.i_UART_DATA_TX_READY = 1'b1;
        tick();
        bus.i_UART_DATA_TX_READY = 1'b0;
        chk("ads_done", 64'({bus.o_UART_DATA_TX_VALID, bus.o_CORE_BUSY}), 64'h0);

        // leftover sample drains before the MPR reply
        send_cmd(8'h52, 8'h00);
        bus.i_SAMPLE_DATA  = 48'h4D01_2345_6789;
        bus.i_SAMPLE_VALID = 1'b1;
        tick();
        bus.i_SAMPLE_VALID = 1'b0;
        chk("smp_buf", 64'({bus.o_SAMPLE_READY, bus.o_UART_DATA_TX_VALID}), 64'b01);
        chk("smp_data", 64'(bus.o_UART_DATA_TX), 64'h4D01_2345_6789);
        send_cmd(8'h53, 8'h00);
        chk("smp_stop", 64'(bus.o_RUN), 64'h0);
        send_cmd(8'h6D, 8'h22);
        chk("mpr_req", 64'({bus.o_MPR_RREG_REQ, bus.o_RREG_ADDR}), 64'h122);
        bus.i_MPR_RREG_DONE = 1'b1;
        bus.i_MPR_RREG_DATA = 8'h9A;
        tick();
        bus.i_MPR_RREG_DONE = 1'b0;
        chk("mpr_smp_first", 64'(bus.o_UART_DATA_TX), 64'h4D01_2345_6789);
        bus.i_UART_DATA_TX_READY = 1'b1;
        tick();
        chk("mpr_reply", 64'(bus.o_UART_DATA_TX), 64'h4D22_9A00_0000);
        chk("mpr_ready_back", 64'({bus.o_SAMPLE_READY, bus.o_UART_DATA_TX_VALID}), 64'b11);
        tick();
        bus.i_UART_DATA_TX_READY = 1'b0;
        chk("mpr_done", 64'({bus.o_UART_DATA_TX_VALID, bus.o_CORE_BUSY}), 64'h0);

        // sample arriving while a reply is on offer must not disturb it
        send_cmd(8'h61, 8'h3C);
        bus.i_ADS_RREG_DONE = 1'b1;
        bus.i_ADS_RREG_DATA = 8'hC5;
        tick();
        bus.i_ADS_RREG_DONE = 1'b0;
        bus.i_SAMPLE_DATA  = 48'h41AA_BBCC_DDEE;
        bus.i_SAMPLE_VALID = 1'b1;
        tick();
        bus.i_SAMPLE_VALID = 1'b0;
        chk("lock_reply", 64'(bus.o_UART_DATA_TX), 64'h413C_C500_0000);
        bus.i_UART_DATA_TX_READY = 1'b1;
        tick();
        chk("lock_then_smp", 64'({bus.o_UART_DATA_TX_VALID, bus.o_UART_DATA_TX}), 64'h1_41AA_BBCC_DDEE);
        tick();
        bus.i_UART_DATA_TX_READY = 1'b0;
        chk("lock_empty", 64'({bus.o_UART_DATA_TX_VALID, bus.o_CORE_BUSY}), 64'h0);

`ifdef UART_CMD_TIMEOUT_EN
        send_cmd(8'h61, 8'h07);
        repeat (15) tick();
        chk("tmo_wait", 64'({bus.o_CMD_ERR, bus.o_ADS_RREG_REQ}), 64'b01);
        tick();
        chk("tmo_err", 64'({bus.o_CMD_ERR, bus.o_ADS_RREG_REQ, bus.o_UART_DATA_TX_VALID}), 64'b101);
        chk("tmo_frame", 64'(bus.o_UART_DATA_TX), 64'h4107_FF00_0000);
        bus.i_UART_DATA_TX_READY = 1'b1;
        tick();
        bus.i_UART_DATA_TX_READY = 1'b0;
`endif

        // reset during reply
        send_cmd(8'h61, 8'h10);
        bus.i_ADS_RREG_DONE = 1'b1;
        bus.i_ADS_RREG_DATA = 8'h11;
        tick();
        bus.i_ADS_RREG_DONE = 1'b0;
        chk("pre_rst_txv", 64'(bus.o_UART_DATA_TX_VALID), 64'h1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_out", 64'({bus.o_UART_DATA_TX_VALID, bus.o_CORE_BUSY, bus.o_ADS_RREG_REQ,
                                bus.o_SAMPLE_READY, bus.o_RREG_ADDR}), 64'h0);
        chk("mid_rst_data", 64'(bus.o_UART_DATA_TX), 64'h0);
        tick();
        rstn = 1'b1;
        bus.i_UART_DATA_TX_READY = 1'b1;
        repeat (3) tick();
        chk("post_rst_quiet", 64'({bus.o_UART_DATA_TX_VALID, bus.o_CORE_BUSY}), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
